pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 151 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
`default_nettype none
//==============================================================================
// Module      : pipe_stage_reg
// Description : Valid/ready pipeline stage register, either a two-entry skid
//               buffer with registered in_ready or a single-entry flow stage.
// Revision    : 1.0 - initial release
//==============================================================================
module pipe_stage_reg #(
    parameter int               WIDTH  = 128,
    parameter logic [WIDTH-1:0] BUBBLE = '0,
    parameter int               SKID   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    // State encoding doubles as the occupancy count.
    localparam logic [1:0] c_ST_EMPTY = 2'd0;
    localparam logic [1:0] c_ST_ONE   = 2'd1;
    localparam logic [1:0] c_ST_FULL  = 2'd2;

    generate
        if (SKID != 0) begin : g_skid
            logic [1:0]       state_q, state_d;
            logic [WIDTH-1:0] main_q, main_d;
            logic [WIDTH-1:0] skid_q, skid_d;
            logic             in_ready_q, in_ready_d;
            logic             w_accept;
            logic             w_retire;

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q    <= c_ST_EMPTY;
                    main_q     <= BUBBLE;
                    skid_q     <= BUBBLE;
                    in_ready_q <= 1'b1;
                end else begin
                    state_q    <= state_d;
                    main_q     <= main_d;
                    skid_q     <= skid_d;
                    in_ready_q <= in_ready_d;
                end
            end

            always_comb begin
                w_accept = in_valid && in_ready_q;
                w_retire = (state_q != c_ST_EMPTY) && out_ready;
                state_d  = state_q;
                main_d   = main_q;
                skid_d   = skid_q;
                if (flush) begin
                    state_d = c_ST_EMPTY;
                    main_d  = BUBBLE;
                    skid_d  = BUBBLE;
                end else begin
                    case (state_q)
                        c_ST_EMPTY: begin
                            if (w_accept) begin
                                state_d = c_ST_ONE;
                                main_d  = in_data;
                            end
                        end
                        c_ST_ONE: begin
                            if (w_accept && !w_retire) begin
                                state_d = c_ST_FULL;
                                skid_d  = in_data;
                            end else if (w_accept && w_retire) begin
                                main_d  = in_data;
                            end else if (w_retire) begin
                                state_d = c_ST_EMPTY;
                                main_d  = BUBBLE;
                            end
                        end
                        c_ST_FULL: begin
                            // in_ready is low here, so only a retire can occur.
                            if (w_retire) begin
                                state_d = c_ST_ONE;
                                main_d  = skid_q;
                                skid_d  = BUBBLE;
                            end
                        end
                        default: begin
                            state_d = c_ST_EMPTY;
                            main_d  = BUBBLE;
                            skid_d  = BUBBLE;
                        end
                    endcase
                end
                in_ready_d = (state_d != c_ST_FULL);
            end

            always_comb begin
                out_valid = (state_q != c_ST_EMPTY);
                out_data  = main_q;
                count     = state_q;
                in_ready  = in_ready_q;
            end
        end else begin : g_single
            logic             valid_q, valid_d;
            logic [WIDTH-1:0] data_q, data_d;
            logic             w_in_ready;
            logic             w_accept;
            logic             w_retire;

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_q <= 1'b0;
                    data_q  <= BUBBLE;
                end else begin
                    valid_q <= valid_d;
                    data_q  <= data_d;
                end
            end

            always_comb begin
                w_in_ready = !valid_q || out_ready;
                w_accept   = in_valid && w_in_ready;
                w_retire   = valid_q && out_ready;
                valid_d    = valid_q;
                data_d     = data_q;
                if (flush) begin
                    valid_d = 1'b0;
                    data_d  = BUBBLE;
                end else if (w_accept) begin
                    valid_d = 1'b1;
                    data_d  = in_data;
                end else if (w_retire) begin
                    valid_d = 1'b0;
                    data_d  = BUBBLE;
                end
            end

            always_comb begin
                out_valid = valid_q;
                out_data  = data_q;
                count     = {1'b0, valid_q};
                in_ready  = w_in_ready;
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
//==============================================================================
// Module      : tb_pipe_stage_reg
// Description : Directed self-checking bench for both SKID variants.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_pipe_stage_reg;

    localparam int               c_W      = 8;
    localparam logic [c_W-1:0]   c_BUBBLE = 8'h5C;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           flush = 1'b0;
    logic           in_valid = 1'b0;
    logic [c_W-1:0] in_data = '0;
    logic           out_ready = 1'b0;

    logic           s1_in_ready, s1_out_valid;
    logic [c_W-1:0] s1_out_data;
    logic [1:0]     s1_count;
    logic           s0_in_ready, s0_out_valid;
    logic [c_W-1:0] s0_out_data;
    logic [1:0]     s0_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(c_W), .BUBBLE(c_BUBBLE), .SKID(1)) u_dut_skid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(s1_in_ready), .in_data(in_data),
        .out_valid(s1_out_valid), .out_ready(out_ready), .out_data(s1_out_data),
        .count(s1_count)
    );

    pipe_stage_reg #(.WIDTH(c_W), .BUBBLE(c_BUBBLE), .SKID(0)) u_dut_flow (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(s0_in_ready), .in_data(in_data),
        .out_valid(s0_out_valid), .out_ready(out_ready), .out_data(s0_out_data),
        .count(s0_count)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (2) step();
        rst = 1'b0;
        check_val("rst_s1_count", 32'(s1_count), 0);
        check_val("rst_s1_valid", 32'(s1_out_valid), 0);
        check_val("rst_s1_data", 32'(s1_out_data), 32'(c_BUBBLE));
        check_val("rst_s1_ready", 32'(s1_in_ready), 1);
        check_val("rst_s0_count", 32'(s0_count), 0);
        check_val("rst_s0_ready", 32'(s0_in_ready), 1);
        check_val("rst_s0_data", 32'(s0_out_data), 32'(c_BUBBLE));

        // Single-entry latency
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
        step();
        in_valid = 1'b0;
        check_val("lat_s1_valid", 32'(s1_out_valid), 1);
        check_val("lat_s1_data", 32'(s1_out_data), 32'hA5);
        check_val("lat_s0_data", 32'(s0_out_data), 32'hA5);
        step();
        check_val("lat_s1_valid_after", 32'(s1_out_valid), 0);
        check_val("lat_s1_bubble", 32'(s1_out_data), 32'(c_BUBBLE));
        check_val("lat_s0_bubble", 32'(s0_out_data), 32'(c_BUBBLE));

        // Stall fills the skid; flow stage shows same-cycle backpressure
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h01;
        step();
        check_val("stall1_count", 32'(s1_count), 1);
        check_val("stall1_ready", 32'(s1_in_ready), 1);
        in_data = 8'h02;
        step();
        check_val("stall2_count", 32'(s1_count), 2);
        check_val("stall2_ready", 32'(s1_in_ready), 0);
        in_data = 8'h03;
        step();
        check_val("stall3_count", 32'(s1_count), 2);
        check_val("stall3_data_hold", 32'(s1_out_data), 32'h01);
        check_val("stall3_valid_hold", 32'(s1_out_valid), 1);
        check_val("flow_bp_ready_low", 32'(s0_in_ready), 0);
        check_val("flow_bp_count", 32'(s0_count), 1);
        check_val("flow_bp_data", 32'(s0_out_data), 32'h01);
        out_ready = 1'b1;
        #1;
        check_val("flow_bp_ready_high", 32'(s0_in_ready), 1);
        check_val("skid_ready_no_comb", 32'(s1_in_ready), 0);
        step();
        check_val("drain_out2", 32'(s1_out_data), 32'h02);
        check_val("drain_count1", 32'(s1_count), 1);
        step();
        in_valid = 1'b0;
        check_val("drain_out3", 32'(s1_out_data), 32'h03);
        check_val("drain_valid3", 32'(s1_out_valid), 1);
        step();
        check_val("drain_empty", 32'(s1_out_valid), 0);
        check_val("drain_bubble", 32'(s1_out_data), 32'(c_BUBBLE));

        // Full throughput
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_data = 8'(8'h10 + i);
            check_val("thru_ready", 32'(s1_in_ready), 1);
            step();
            check_val("thru_data", 32'(s1_out_data), 32'(8'(8'h10 + i)));
            check_val("thru_count", 32'(s1_count), 1);
        end
        in_valid = 1'b0;
        step();
        check_val("thru_empty", 32'(s1_count), 0);

        // Flush while FULL with an offered entry
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h41;
        step();
        in_data = 8'h42;
        step();
        check_val("flfull_pre_count", 32'(s1_count), 2);
        flush = 1'b1; in_data = 8'h77;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check_val("flfull_count", 32'(s1_count), 0);
        check_val("flfull_valid", 32'(s1_out_valid), 0);
        check_val("flfull_bubble", 32'(s1_out_data), 32'(c_BUBBLE));
        check_val("flfull_ready", 32'(s1_in_ready), 1);
        check_val("flfull_s0_valid", 32'(s0_out_valid), 0);
        out_ready = 1'b1;
        repeat (2) begin
            step();
            check_val("flfull_no77", 32'(s1_out_valid), 0);
        end

        // Flush from ONE with in_ready high: offered entry discarded
        in_valid = 1'b1; in_data = 8'h50;
        step();
        flush = 1'b1; in_data = 8'h77; out_ready = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check_val("flone_s1_valid", 32'(s1_out_valid), 0);
        check_val("flone_s1_count", 32'(s1_count), 0);
        check_val("flone_s0_valid", 32'(s0_out_valid), 0);
        check_val("flone_s0_bubble", 32'(s0_out_data), 32'(c_BUBBLE));

        // Reset mid-stream with two held entries
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h61;
        step();
        in_data = 8'h62;
        step();
        check_val("rstmid_pre_count", 32'(s1_count), 2);
        rst = 1'b1; in_data = 8'h63;
        step();
        rst = 1'b0; in_valid = 1'b0;
        check_val("rstmid_count", 32'(s1_count), 0);
        check_val("rstmid_valid", 32'(s1_out_valid), 0);
        check_val("rstmid_ready", 32'(s1_in_ready), 1);
        check_val("rstmid_bubble", 32'(s1_out_data), 32'(c_BUBBLE));
        check_val("rstmid_s0_valid", 32'(s0_out_valid), 0);
        out_ready = 1'b1;
        repeat (2) begin
            step();
            check_val("rstmid_no_stale", 32'(s1_out_valid), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
